// File: rtl/instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Instruction prefetch stage placed directly in front of fetch. It issues
// word-aligned requests to instruction memory, keeps the returned words in an
// in-order FIFO and hands {addr, instr} to fetch over a valid/ready handshake.
// A redirect (taken branch/jump) flushes the FIFO, marks every response still
// in flight for discard, and restarts fetching at the redirect target.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   redirect_valid  restart fetching at redirect_addr (word aligned internally)
//   redirect_addr   redirect target
//   mem_req         request to instruction memory (combinational)
//   mem_addr        request address
//   mem_gnt         memory accepted the request (mem_req & mem_gnt = issue)
//   mem_rvalid      read data valid, responses in request order
//   mem_rdata       read data
//   out_valid       FIFO head valid toward fetch
//   out_addr        head instruction address (0 when empty)
//   out_instr       head instruction word (0 when empty)
//   out_ready       fetch consumes the head (out_valid & out_ready = pop)
// ---------------------------------------------------------------------------
module instr_prefetch_buffer #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_addr,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;

  logic [31:0]   fifo_addr_q  [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];

  logic [CW+1:0] credits_used;
  logic [31:0]   redirect_target;
  logic          issue;
  logic          drop;
  logic          push;
  logic          pop;

  // Responses still owed to the discard counter occupy a credit as well:
  // this bounds discard by DEPTH even across repeated redirects while old
  // responses are still trickling back.
  assign credits_used = (CW+2)'(count_q) + (CW+2)'(outst_q) + (CW+2)'(disc_q);

  assign mem_req  = rst & ~redirect_valid & (credits_used < DEPTH_C);
  assign mem_addr = fetch_pc_q;

  assign redirect_target = redirect_addr & 32'hFFFF_FFFC;

  assign issue = mem_req & mem_gnt;
  assign drop  = mem_rvalid & (disc_q != '0);
  assign push  = mem_rvalid & (disc_q == '0) & (outst_q != '0);
  assign pop   = out_valid & out_ready & ~redirect_valid;

  assign out_valid = (count_q != '0);
  assign out_addr  = out_valid ? fifo_addr_q[rptr_q]  : 32'h0;
  assign out_instr = out_valid ? fifo_instr_q[rptr_q] : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d    = outst_d + CW'(1);
    end
    if (drop) begin
      disc_d = disc_q - CW'(1);
    end
    if (push) begin
      outst_d   = outst_d - CW'(1);
      resp_pc_d = resp_pc_q + 32'd4;
      wptr_d    = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // The same-cycle response has already been accounted for above, so
    // whatever is still outstanding now belongs to the abandoned stream.
    if (redirect_valid) begin
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      disc_d     = disc_d + outst_d;
      outst_d    = '0;
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_ADDR;
      resp_pc_q  <= RESET_ADDR;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q]  <= resp_pc_q;
      fifo_instr_q[wptr_q] <= mem_rdata;
    end
  end

endmodule
